float_mul_pipe: RTL and testbench
=================================

FLOAT_MUL_PIPE -- requirements
Module: float_mul_pipe

Interface
REQ-001 Parameter E_BIT, default 8, is the exponent field width.
REQ-002 Parameter F_BIT, default 23, is the fraction field width; operand width W = 1+E_BIT+F_BIT.
REQ-003 Parameter TAG_W, default 4, is the sideband tag width carried alongside each operation.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  operand pair present.
REQ-008 in_ready  out  1  block accepts the pair this cycle.
REQ-009 in_a, in_b  in  W  IEEE-style operands {sign, exponent, fraction}.
REQ-010 in_tag  in  TAG_W  sideband, returned unchanged with its result.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer takes the result this cycle.
REQ-013 out_p  out  W  product.
REQ-014 out_tag  out  TAG_W  tag of the product on out_p.
REQ-015 out_flags  out  4  {invalid, overflow, underflow, inexact}.

Function
REQ-016 The datapath SHALL be a 3-stage pipeline: S1 decode, special-case detection, significand product, exponent sum; S2 normalise, round; S3 exponent adjust, range check, pack.
REQ-017 The pipeline SHALL advance when adv = out_ready | !out_valid; in_ready = adv; a transfer occurs on in_valid & in_ready.
REQ-018 With adv held high, a result accepted at edge N SHALL appear on out_p/out_tag/out_flags with out_valid=1 after edge N+3.
REQ-019 A stall (adv=0) SHALL freeze all stage registers; no result or tag is lost or duplicated; bubbles are not compressed.
REQ-020 Result sign SHALL be sign(a) XOR sign(b) for all non-NaN results.
REQ-021 An operand with exponent 0 (zero or subnormal) SHALL be treated as zero.
REQ-022 NaN input, or infinity times zero, SHALL yield canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0; invalid=1.
REQ-023 Infinity times nonzero finite or infinity SHALL yield signed infinity, no flags.
REQ-024 Zero times finite SHALL yield signed zero, no flags.
REQ-025 Significand product SHALL be (F_BIT+1)x(F_BIT+1) giving 2*F_BIT+2 bits; if MSB set, shift right one and increment exponent.
REQ-026 Biased exponent SHALL be computed as ea+eb-(2^(E_BIT-1)-1) in E_BIT+2 signed bits, with no wrap.
REQ-027 A rounding carry-out of the fraction SHALL renormalise (fraction 0, exponent+1) before the range check.
REQ-028 Final exponent >= 2^E_BIT-1 SHALL yield signed infinity with overflow=1 and inexact=1.
REQ-029 Final exponent <= 0 SHALL yield signed zero with underflow=1 and inexact=1; no subnormal outputs.
REQ-030 inexact SHALL be 1 whenever discarded product bits are nonzero.

Reset
REQ-031 While rst=1, all stage valid bits SHALL clear: out_valid=0, out_p=0, out_tag=0, out_flags=0; in_ready=1.
REQ-032 Operations in flight at reset assertion SHALL be discarded; the first accept after rst deasserts behaves as from power-up.

Configuration
REQ-033 With macro FMUL_RNE_EN defined, rounding SHALL be round-to-nearest, ties-to-even using guard and sticky bits.
REQ-034 Without FMUL_RNE_EN, rounding SHALL be truncation toward zero; inexact is still reported.

Verification
REQ-035 Basic: 0x3FC00000 x 0x40000000, tag 5, out_ready=1 -> 0x40400000, tag 5, flags 0, three cycles after accept.
REQ-036 Tie: 0x3FC00000 x 0x3F800001 -> 0x3FC00002 with FMUL_RNE_EN, 0x3FC00001 without; inexact=1 in both builds.
REQ-037 Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0.
REQ-038 Range: 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow+inexact; 0x00800000 x 0x00800000 -> 0x00000000, underflow+inexact.
REQ-039 Backpressure: stream 6 ops, tags 0-5, with out_ready low for 4 cycles mid-stream -> in_ready low during the stall; all 6 results emerge in order with correct tags.
REQ-040 Reset mid-op: assert rst with 3 ops in flight -> out_valid=0 at once; no stale result after release.

Source files
------------

// File: rtl/float_mul_pipe.sv
// float_mul_pipe: IEEE-style multiplier with an operand register and three compute stages.
// The pipeline stalls as a whole on valid/ready. FMUL_RNE_EN selects round-nearest-even; the default rounding is truncation.
module float_mul_pipe #(
  parameter int E_BIT = 8,
  parameter int F_BIT = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [E_BIT+F_BIT:0] in_a,
  input  logic [E_BIT+F_BIT:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [E_BIT+F_BIT:0] out_p,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);
  localparam int W  = 1 + E_BIT + F_BIT;
  localparam int PW = 2*F_BIT + 2;
  localparam int XW = E_BIT + 2;
  localparam logic [XW-1:0]    BIAS    = XW'((1 << (E_BIT-1)) - 1);
  localparam logic [XW-1:0]    EXP_OVF = XW'((1 << E_BIT) - 1);
  localparam logic [E_BIT-1:0] EMAX    = '1;
  localparam logic [1:0] C_NUM = 2'd0, C_ZERO = 2'd1, C_INF = 2'd2, C_NAN = 2'd3;

  typedef struct packed {
    logic             sign;
    logic [1:0]       cls;
    logic [PW-1:0]    prod;
    logic [XW-1:0]    ex;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [1:0]       cls;
    logic [F_BIT-1:0] frac;
    logic             carry;
    logic [XW-1:0]    ex;
    logic             inexact;
    logic [TAG_W-1:0] tag;
  } s2_t;

  // r_vld_pipe[0] is the operand register, and [3] is the output register.
  logic [3:0]       r_vld_pipe;
  logic [W-1:0]     r_a, r_b;
  logic [TAG_W-1:0] r_tag0;
  s1_t              r_s1, w_s1;
  s2_t              r_s2, w_s2;
  logic [W-1:0]     r_p, w_p;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_flags, w_flags;
  logic             w_adv;

  assign w_adv     = out_ready | ~r_vld_pipe[3];
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[3];
  assign out_p     = r_p;
  assign out_tag   = r_tag;
  assign out_flags = r_flags;

  // S1: decode, classify, significand product, exponent sum
  logic [E_BIT-1:0] w_ea, w_eb;
  logic [F_BIT-1:0] w_fa, w_fb;
  logic w_za, w_zb, w_ia, w_ib, w_na, w_nb;

  assign w_ea = r_a[W-2:F_BIT];
  assign w_eb = r_b[W-2:F_BIT];
  assign w_fa = r_a[F_BIT-1:0];
  assign w_fb = r_b[F_BIT-1:0];
  assign w_za = (w_ea == '0);
  assign w_zb = (w_eb == '0);
  assign w_ia = (w_ea == EMAX) && (w_fa == '0);
  assign w_ib = (w_eb == EMAX) && (w_fb == '0);
  assign w_na = (w_ea == EMAX) && (w_fa != '0);
  assign w_nb = (w_eb == EMAX) && (w_fb != '0);

  always_comb begin
    w_s1      = '0;
    w_s1.sign = r_a[W-1] ^ r_b[W-1];
    w_s1.tag  = r_tag0;
    w_s1.prod = {{(F_BIT+1){1'b0}}, 1'b1, w_fa} * {{(F_BIT+1){1'b0}}, 1'b1, w_fb};
    w_s1.ex   = XW'(w_ea) + XW'(w_eb) - BIAS;
    if (w_na | w_nb | (w_ia & w_zb) | (w_za & w_ib)) w_s1.cls = C_NAN;
    else if (w_ia | w_ib)                            w_s1.cls = C_INF;
    else if (w_za | w_zb)                            w_s1.cls = C_ZERO;
    else                                             w_s1.cls = C_NUM;
  end

  // S2: normalise to a leading one, then round
  logic             w_msb, w_guard, w_sticky, w_up;
  logic [F_BIT-1:0] w_frac;

  assign w_msb    = r_s1.prod[PW-1];
  assign w_frac   = w_msb ? r_s1.prod[PW-2 -: F_BIT] : r_s1.prod[PW-3 -: F_BIT];
  assign w_guard  = w_msb ? r_s1.prod[F_BIT]         : r_s1.prod[F_BIT-1];
  assign w_sticky = w_msb ? |r_s1.prod[F_BIT-1:0]    : |r_s1.prod[F_BIT-2:0];
`ifdef FMUL_RNE_EN
  assign w_up = w_guard & (w_sticky | w_frac[0]);
`else
  assign w_up = 1'b0;
`endif

  always_comb begin
    w_s2         = '0;
    w_s2.sign    = r_s1.sign;
    w_s2.cls     = r_s1.cls;
    w_s2.tag     = r_s1.tag;
    w_s2.inexact = w_guard | w_sticky;
    w_s2.ex      = r_s1.ex + {{(XW-1){1'b0}}, w_msb};
    {w_s2.carry, w_s2.frac} = {1'b0, w_frac} + {{F_BIT{1'b0}}, w_up};
  end

  // S3: when the rounding carry is set, frac has already wrapped to zero, so only the exponent moves.
  logic signed [XW-1:0] w_exp3;
  assign w_exp3 = $signed(r_s2.ex + {{(XW-1){1'b0}}, r_s2.carry});

  always_comb begin
    w_p     = '0;
    w_flags = '0;
    case (r_s2.cls)
      C_NAN: begin
        w_p     = {1'b0, EMAX, 1'b1, {(F_BIT-1){1'b0}}};
        w_flags = 4'b1000;
      end
      C_INF:  w_p = {r_s2.sign, EMAX, {F_BIT{1'b0}}};
      C_ZERO: w_p = {r_s2.sign, {(W-1){1'b0}}};
      default: begin
        if (w_exp3 <= 0) begin
          w_p     = {r_s2.sign, {(W-1){1'b0}}};
          w_flags = 4'b0011;
        end else if (w_exp3 >= $signed(EXP_OVF)) begin
          w_p     = {r_s2.sign, EMAX, {F_BIT{1'b0}}};
          w_flags = 4'b0101;
        end else begin
          w_p     = {r_s2.sign, w_exp3[E_BIT-1:0], r_s2.frac};
          w_flags = {3'b000, r_s2.inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_tag0     <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_p        <= '0;
      r_tag      <= '0;
      r_flags    <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[2:0], in_valid};
      r_a        <= in_a;
      r_b        <= in_b;
      r_tag0     <= in_tag;
      r_s1       <= w_s1;
      r_s2       <= w_s2;
      r_p        <= w_p;
      r_tag      <= r_s2.tag;
      r_flags    <= w_flags;
    end
  end
endmodule

// File: tb/tb_float_mul_pipe.sv
// Scoreboard bench for float_mul_pipe (single precision); expectations follow the FMUL_RNE_EN build.
module tb_float_mul_pipe;
`ifdef FMUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0, out_p;
  logic [3:0]  in_tag = '0, out_tag, out_flags;

  float_mul_pipe #(.E_BIT(8), .F_BIT(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] p; logic [3:0] tag; logic [3:0] flg; int acc; bit lat; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] p; logic [3:0] flg; } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] p, input logic [3:0] flg, input bit lat);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    else sb.push_back('{p, tag, flg, cyc + 1, lat});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  always begin : mon
    exp_t e;
    @(negedge clk); #1;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk($sformatf("p_tag%0d", e.tag), out_p, e.p);
        chk($sformatf("tag_tag%0d", e.tag), 32'(out_tag), 32'(e.tag));
        chk($sformatf("flags_tag%0d", e.tag), 32'(out_flags), 32'(e.flg));
        if (e.lat) chk("latency", 32'(cyc - e.acc), 3);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stale;
    vt = '{
      '{32'h3FC00000, 32'h3F800001, RNE ? 32'h3FC00002 : 32'h3FC00001, 4'b0001},
      '{32'h3F800001, 32'h3FFFFFFE, RNE ? 32'h40000000 : 32'h3FFFFFFF, 4'b0001},
      '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001},
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
      '{32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000},
      '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000},
      '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000},
      '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101},
      '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101},
      '{32'h7F000000, 32'h3FFFFFFE, 32'h7F7FFFFE, 4'b0000},
      '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011},
      '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
      '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000},
      '{32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000},
      '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000},
      '{32'h00000001, 32'hFF000000, 32'h80000000, 4'b0000}
    };

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk) rst = 1'b0;

    send(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000, 1'b1);
    drain();

    foreach (vt[i]) send(vt[i].a, vt[i].b, 4'(i), vt[i].p, vt[i].flg, 1'b0);
    drain();

    // The first result is out before the stall begins, so in_ready must drop.
    fork
      for (int i = 0; i < 6; i++)
        send(32'h3FC00000, 32'(127 + i) << 23, 4'(i), 32'h3FC00000 + (32'(i) << 23), 4'b0000, 1'b0);
      begin
        repeat (6) @(negedge clk);
        repeat (4) begin
          out_ready = 1'b0;
          #1 chk("stall_in_ready", 32'(in_ready), 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++)
      send(32'h40000000, 32'h40000000, 4'(8 + i), 32'h40800000, 4'b0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_p", out_p, 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    chk("stale_after_rst", 32'(stale), 0);

    send(32'h3FC00000, 32'h40000000, 4'd7, 32'h40400000, 4'b0000, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
